delay_ram_sched: RTL and testbench

Two-channel scheduler for one shared single-port delay BRAM in the audio-effects path. It accepts left/right sample strobes from the codec side and arbitrates them round-robin onto the single RAM port. For each sample it runs a read-then-write transaction against that channel's circular region and returns the sample delayed by a runtime-programmable number of samples. It sits between the I2S sample interface and the echo/feedback mixing stage, and replaces per-channel private delay RAMs.

---
 rtl/echo_pkg.sv | 15 +
 rtl/delay_ram_sched_if.sv | 26 ++
 rtl/delay_ptr.sv | 64 ++++++
 rtl/delay_ram_sched.sv | 136 +++++++++++++
 tb/tb_delay_ram_sched.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/echo_pkg.sv
// Shared constants for the delay-RAM scheduler: default sizes, FSM encodings, channel ids.
package echo_pkg;

  localparam int unsigned WIDTH    = 24;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned CH_DEPTH = 24000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

endpackage

// File: rtl/delay_ram_sched_if.sv
// Single-port delay RAM bus: scheduler drives address/we/data, RAM returns registered q.
interface delay_ram_sched_if #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned ADDR_W = 16
);

  logic [ADDR_W-1:0] o_ram_addr;
  logic              o_ram_we;
  logic [WIDTH-1:0]  o_ram_data;
  logic [WIDTH-1:0]  i_ram_q;

  modport master (
    output o_ram_addr,
    output o_ram_we,
    output o_ram_data,
    input  i_ram_q
  );

  modport slave (
    input  o_ram_addr,
    input  o_ram_we,
    input  o_ram_data,
    output i_ram_q
  );

endinterface

// File: rtl/delay_ptr.sv
// Per-channel bookkeeping: sample holding register, pending/overrun, write pointer
// and the clamped read pointer for the currently programmed delay.
module delay_ptr #(
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned CH_DEPTH = 24000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_dv,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_grant,
  input  logic              i_advance,
  input  logic [ADDR_W-1:0] i_delay_len,
  output logic              o_pending,
  output logic              o_ovf,
  output logic [WIDTH-1:0]  o_hold,
  output logic [ADDR_W-1:0] o_wp,
  output logic [ADDR_W-1:0] o_rp
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(CH_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(CH_DEPTH - 1);

  logic [ADDR_W-1:0] d;

  // Sample capture, overrun detection and write-pointer advance.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_pending <= 1'b0;
      o_ovf     <= 1'b0;
      o_hold    <= '0;
      o_wp      <= '0;
    end else begin
      // A new strobe wins over a grant on the same edge: the old word has just
      // been taken by the scheduler, so pending stays set without an overrun.
      if (i_dv) begin
        o_hold    <= i_data;
        o_pending <= 1'b1;
        if (o_pending && !i_grant)
          o_ovf <= 1'b1;
      end else if (i_grant) begin
        o_pending <= 1'b0;
      end
      if (i_advance)
        o_wp <= (o_wp == LAST_A) ? '0 : o_wp + 1'b1;
    end
  end

  // Clamp delay into 1..CH_DEPTH and step back from wp with wrap-around.
  always_comb begin
    if (i_delay_len == '0)
      d = {{(ADDR_W-1){1'b0}}, 1'b1};
    else if (i_delay_len > DEPTH_A)
      d = DEPTH_A;
    else
      d = i_delay_len;
    if (o_wp >= d)
      o_rp = o_wp - d;
    else
      o_rp = DEPTH_A - (d - o_wp);
  end

endmodule

// File: rtl/delay_ram_sched.sv
// Two-channel round-robin scheduler sharing one single-port delay RAM.
// Each sample runs IDLE(grant, read addr) -> READ(write addr) -> WRITE(capture q).
module delay_ram_sched #(
  parameter int unsigned WIDTH    = echo_pkg::WIDTH,
  parameter int unsigned ADDR_W   = echo_pkg::ADDR_W,
  parameter int unsigned CH_DEPTH = echo_pkg::CH_DEPTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [WIDTH-1:0]   i_l_data,
  input  logic [WIDTH-1:0]   i_r_data,
  input  logic               i_l_DV,
  input  logic               i_r_DV,
  input  logic [ADDR_W-1:0]  i_delay_len,
  output logic [WIDTH-1:0]   o_l_data,
  output logic [WIDTH-1:0]   o_r_data,
  output logic               o_l_DV,
  output logic               o_r_DV,
  output logic               o_l_ovf,
  output logic               o_r_ovf,
  delay_ram_sched_if.master  ram
);

  import echo_pkg::*;

  localparam logic [ADDR_W-1:0] R_BASE = ADDR_W'(CH_DEPTH);

  logic [1:0]        state;
  logic              cur_ch;
  logic              last_ch;
  logic [WIDTH-1:0]  txn_data;

  logic              grant_l, grant_r;
  logic              adv_l, adv_r;
  logic              l_pend, r_pend;
  logic [WIDTH-1:0]  l_hold, r_hold;
  logic [ADDR_W-1:0] l_wp, r_wp, l_rp, r_rp;

  delay_ptr #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CH_DEPTH(CH_DEPTH)) u_ptr_l (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_dv        (i_l_DV),
    .i_data      (i_l_data),
    .i_grant     (grant_l),
    .i_advance   (adv_l),
    .i_delay_len (i_delay_len),
    .o_pending   (l_pend),
    .o_ovf       (o_l_ovf),
    .o_hold      (l_hold),
    .o_wp        (l_wp),
    .o_rp        (l_rp)
  );

  delay_ptr #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CH_DEPTH(CH_DEPTH)) u_ptr_r (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_dv        (i_r_DV),
    .i_data      (i_r_data),
    .i_grant     (grant_r),
    .i_advance   (adv_r),
    .i_delay_len (i_delay_len),
    .o_pending   (r_pend),
    .o_ovf       (o_r_ovf),
    .o_hold      (r_hold),
    .o_wp        (r_wp),
    .o_rp        (r_rp)
  );

  // Round-robin grant in IDLE: on contention the channel not served last wins.
  always_comb begin
    grant_l = 1'b0;
    grant_r = 1'b0;
    if (state == ST_IDLE) begin
      if (l_pend && (!r_pend || last_ch == CH_R))
        grant_l = 1'b1;
      else if (r_pend)
        grant_r = 1'b1;
    end
  end

  assign adv_l = (state == ST_WRITE) && (cur_ch == CH_L);
  assign adv_r = (state == ST_WRITE) && (cur_ch == CH_R);

  // Transaction FSM and registered RAM port / channel outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      cur_ch         <= CH_L;
      last_ch        <= CH_R;
      txn_data       <= '0;
      ram.o_ram_addr <= '0;
      ram.o_ram_we   <= 1'b0;
      ram.o_ram_data <= '0;
      o_l_data       <= '0;
      o_r_data       <= '0;
      o_l_DV         <= 1'b0;
      o_r_DV         <= 1'b0;
    end else begin
      o_l_DV <= 1'b0;
      o_r_DV <= 1'b0;
      case (state)
        ST_IDLE: begin
          // rp is combinational from i_delay_len; registering the address here
          // is what samples the delay at the grant edge.
          if (grant_l || grant_r) begin
            cur_ch         <= grant_l ? CH_L : CH_R;
            txn_data       <= grant_l ? l_hold : r_hold;
            ram.o_ram_addr <= grant_l ? l_rp : R_BASE + r_rp;
            ram.o_ram_we   <= 1'b0;
            state          <= ST_READ;
          end
        end
        ST_READ: begin
          ram.o_ram_addr <= (cur_ch == CH_L) ? l_wp : R_BASE + r_wp;
          ram.o_ram_we   <= 1'b1;
          ram.o_ram_data <= txn_data;
          state          <= ST_WRITE;
        end
        ST_WRITE: begin
          ram.o_ram_we <= 1'b0;
          if (cur_ch == CH_L) begin
            o_l_data <= ram.i_ram_q;
            o_l_DV   <= 1'b1;
          end else begin
            o_r_data <= ram.i_ram_q;
            o_r_DV   <= 1'b1;
          end
          last_ch <= cur_ch;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_ram_sched.sv
// Bench for delay_ram_sched: RAM model plus a per-channel circular-buffer reference.
module tb_delay_ram_sched;

  localparam int unsigned WIDTH  = 24;
  localparam int unsigned ADDR_W = 16;
  localparam int          D      = 20;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               issue;
    int               lmin;
    int               lmax;
  } out_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_t;

  logic              clk;
  logic              rst_n;
  logic [WIDTH-1:0]  l_data, r_data;
  logic              l_dv, r_dv;
  logic [ADDR_W-1:0] delay_len;
  logic [WIDTH-1:0]  o_l_data, o_r_data;
  logic              o_l_dv, o_r_dv, o_l_ovf, o_r_ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [WIDTH-1:0] mem   [0:2*D-1];
  logic [WIDTH-1:0] mem_m [2][D];
  int               wp_m  [2];
  out_t             oq_l[$], oq_r[$];
  wr_t              wq_l[$], wq_r[$];
  logic             prev_l, prev_r, prev_we;

  delay_ram_sched_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  delay_ram_sched #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CH_DEPTH(D)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_l_data    (l_data),
    .i_r_data    (r_data),
    .i_l_DV      (l_dv),
    .i_r_DV      (r_dv),
    .i_delay_len (delay_len),
    .o_l_data    (o_l_data),
    .o_r_data    (o_r_data),
    .o_l_DV      (o_l_dv),
    .o_r_DV      (o_r_dv),
    .o_l_ovf     (o_l_ovf),
    .o_r_ovf     (o_r_ovf),
    .ram         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM with registered read address.
  always @(posedge clk) begin
    if (bus.o_ram_addr < ADDR_W'(2*D)) begin
      if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_data;
      bus.i_ram_q <= mem[bus.o_ram_addr];
    end else begin
      bus.i_ram_q <= '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: each channel is a D-word circular buffer; a sample reads the word
  // written d samples ago, then overwrites the current slot.
  task automatic accept(input int ch, input logic [WIDTH-1:0] x, input int dlen,
                        input int issue, input int lmin, input int lmax);
    int   dd, rp;
    out_t o;
    wr_t  w;
    dd = (dlen == 0) ? 1 : ((dlen > D) ? D : dlen);
    rp = (wp_m[ch] - dd + D) % D;
    o.data  = mem_m[ch][rp];
    o.issue = issue;
    o.lmin  = lmin;
    o.lmax  = lmax;
    w.addr  = ADDR_W'(ch * D + wp_m[ch]);
    w.data  = x;
    mem_m[ch][wp_m[ch]] = x;
    wp_m[ch] = (wp_m[ch] + 1) % D;
    if (ch == 0) begin oq_l.push_back(o); wq_l.push_back(w); end
    else         begin oq_r.push_back(o); wq_r.push_back(w); end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic l, input logic r, input logic [WIDTH-1:0] ld, input logic [WIDTH-1:0] rd);
    l_dv = l; r_dv = r; l_data = ld; r_data = rd;
    tick(1);
    l_dv = 1'b0; r_dv = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    wp_m[0] = 0;
    wp_m[1] = 0;
  endtask

  task automatic chk_zero_outputs(input string ph);
    chk({ph, "_l_data"}, o_l_data, 0);
    chk({ph, "_r_data"}, o_r_data, 0);
    chk({ph, "_l_dv"},   o_l_dv, 0);
    chk({ph, "_r_dv"},   o_r_dv, 0);
    chk({ph, "_l_ovf"},  o_l_ovf, 0);
    chk({ph, "_r_ovf"},  o_r_ovf, 0);
    chk({ph, "_addr"},   bus.o_ram_addr, 0);
    chk({ph, "_we"},     bus.o_ram_we, 0);
    chk({ph, "_wdata"},  bus.o_ram_data, 0);
  endtask

  // Output / write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    out_t o;
    wr_t  w;
    int   lat;
    if (o_l_dv) begin
      chk("l_dv_width", prev_l, 0);
      if (oq_l.size() == 0) chk("l_dv_unexpected", 1, 0);
      else begin
        o = oq_l.pop_front();
        lat = cyc - o.issue;
        chk("l_data", o_l_data, o.data);
        chk("l_latency", lat, (lat >= o.lmin && lat <= o.lmax) ? lat : o.lmin);
      end
    end
    if (o_r_dv) begin
      chk("r_dv_width", prev_r, 0);
      if (oq_r.size() == 0) chk("r_dv_unexpected", 1, 0);
      else begin
        o = oq_r.pop_front();
        lat = cyc - o.issue;
        chk("r_data", o_r_data, o.data);
        chk("r_latency", lat, (lat >= o.lmin && lat <= o.lmax) ? lat : o.lmin);
      end
    end
    if (bus.o_ram_we) begin
      chk("we_width", prev_we, 0);
      if (bus.o_ram_addr < ADDR_W'(D)) begin
        if (wq_l.size() == 0) chk("l_write_unexpected", bus.o_ram_addr, 32'hffff_ffff);
        else begin
          w = wq_l.pop_front();
          chk("l_write_addr", bus.o_ram_addr, w.addr);
          chk("l_write_data", bus.o_ram_data, w.data);
        end
      end else if (bus.o_ram_addr < ADDR_W'(2*D)) begin
        if (wq_r.size() == 0) chk("r_write_unexpected", bus.o_ram_addr, 32'hffff_ffff);
        else begin
          w = wq_r.pop_front();
          chk("r_write_addr", bus.o_ram_addr, w.addr);
          chk("r_write_data", bus.o_ram_data, w.data);
        end
      end else begin
        chk("write_addr_range", bus.o_ram_addr, 0);
      end
    end
    prev_l  <= o_l_dv;
    prev_r  <= o_r_dv;
    prev_we <= bus.o_ram_we;
  end

  initial begin
    logic [WIDTH-1:0] a, b;
    int d, mode, off;

    prev_l = 1'b0; prev_r = 1'b0; prev_we = 1'b0;
    for (int unsigned i = 0; i < 2*D; i++) mem[i] = '0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < D; i++) mem_m[c][i] = '0;
    rst_n = 1'b0; l_dv = 1'b0; r_dv = 1'b0; l_data = '0; r_data = '0; delay_len = '0;
    tick(3);
    chk_zero_outputs("reset");
    do_reset();

    // Single channel, d=4: four zeros then the input sequence, latency 3.
    delay_len = 4;
    for (int n = 1; n <= 10; n++) begin
      send(1'b1, 1'b0, WIDTH'(n), '0);
      accept(0, WIDTH'(n), 4, cyc, 3, 3);
      tick(19);
    end

    // Both channels on the same edge after reset: L first, R three cycles later.
    do_reset();
    delay_len = 2;
    for (int n = 0; n < 8; n++) begin
      send(1'b1, 1'b1, WIDTH'(100 + n), WIDTH'(200 + n));
      accept(0, WIDTH'(100 + n), 2, cyc, 3, 3);
      accept(1, WIDTH'(200 + n), 2, cyc, 6, 6);
      tick(19);
    end
    chk("simul_l_ovf", o_l_ovf, 0);
    chk("simul_r_ovf", o_r_ovf, 0);

    // Full-depth delay across two wraps, then d=0 acting as d=1.
    do_reset();
    delay_len = ADDR_W'(D);
    for (int k = 0; k < 2*D + 5; k++) begin
      a = WIDTH'($urandom);
      send(1'b1, 1'b0, a, '0);
      accept(0, a, D, cyc, 3, 3);
      tick(7);
    end
    delay_len = '0;
    for (int k = 0; k < 4; k++) begin
      a = WIDTH'($urandom);
      send(1'b1, 1'b0, a, '0);
      accept(0, a, 0, cyc, 3, 3);
      tick(7);
    end

    // Strobe on the grant edge of the previous sample: no overrun.
    do_reset();
    delay_len = 3;
    a = 24'h0a0a0a; b = 24'h0b0b0b;
    send(1'b1, 1'b0, a, '0);
    accept(0, a, 3, cyc, 3, 3);
    send(1'b1, 1'b0, b, '0);
    accept(0, b, 3, cyc, 5, 5);
    tick(12);
    chk("grant_edge_no_ovf", o_l_ovf, 0);

    // Two L strobes while R owns the port: overrun, second sample wins.
    send(1'b0, 1'b1, '0, 24'h0c0c0c);
    accept(1, 24'h0c0c0c, 3, cyc, 3, 3);
    send(1'b1, 1'b0, 24'h0d0d0d, '0);
    tick(1);
    send(1'b1, 1'b0, 24'h0e0e0e, '0);
    accept(0, 24'h0e0e0e, 3, cyc, 3, 3);
    tick(12);
    chk("ovf_l_set", o_l_ovf, 1);
    chk("ovf_r_clear", o_r_ovf, 0);

    // Reset while READ: transaction dropped, outputs cleared, pointers back to base.
    delay_len = 5;
    send(1'b1, 1'b0, 24'h123456, '0);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    chk_zero_outputs("rst_in_read");
    tick(1);
    rst_n = 1'b1;
    wp_m[0] = 0;
    wp_m[1] = 0;
    tick(2);
    send(1'b1, 1'b0, 24'h654321, '0);
    accept(0, 24'h654321, 5, cyc, 3, 3);
    tick(10);
    send(1'b0, 1'b1, '0, 24'h777777);
    accept(1, 24'h777777, 5, cyc, 3, 3);
    tick(10);

    // Randomized rounds: random delay (including out-of-range), channel mix and skew.
    for (int rnd = 0; rnd < 80; rnd++) begin
      d = int'($urandom_range(0, D + 3));
      delay_len = ADDR_W'(d);
      mode = int'($urandom_range(0, 3));
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      if (mode == 0) begin
        send(1'b1, 1'b0, a, '0);
        accept(0, a, d, cyc, 3, 3);
      end else if (mode == 1) begin
        send(1'b0, 1'b1, '0, b);
        accept(1, b, d, cyc, 3, 3);
      end else if (mode == 2) begin
        send(1'b1, 1'b1, a, b);
        accept(0, a, d, cyc, 3, 6);
        accept(1, b, d, cyc, 3, 6);
      end else begin
        off = int'($urandom_range(1, 2));
        if ($urandom_range(0, 1) == 0) begin
          send(1'b1, 1'b0, a, '0);
          accept(0, a, d, cyc, 3, 3);
          if (off > 1) tick(off - 1);
          send(1'b0, 1'b1, '0, b);
          accept(1, b, d, cyc, 3, 6);
        end else begin
          send(1'b0, 1'b1, '0, b);
          accept(1, b, d, cyc, 3, 3);
          if (off > 1) tick(off - 1);
          send(1'b1, 1'b0, a, '0);
          accept(0, a, d, cyc, 3, 6);
        end
      end
      tick(14);
    end
    chk("rand_l_ovf", o_l_ovf, 0);
    chk("rand_r_ovf", o_r_ovf, 0);

    tick(10);
    chk("l_outputs_pending", oq_l.size(), 0);
    chk("r_outputs_pending", oq_r.size(), 0);
    chk("l_writes_pending", wq_l.size(), 0);
    chk("r_writes_pending", wq_r.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
